// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add/subtract unit.
//   state_e  : FSM state encoding (StIdle/StRun/StDone)
//   ModeAdd / ModeSub : values of the sub request input
//   clog2    : ceiling log2, used to size the bit counter
package serial_add_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic ModeAdd = 1'b0;
  localparam logic ModeSub = 1'b1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fa_bit.sv
// Combinational 1-bit full adder.
//   a, b, cin : addend bits and carry in
//   s, cout   : sum bit and carry out
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_n.sv
// Bit-serial add/subtract unit. Latches two WIDTH-bit operands on start, resolves one bit per
// clock LSB-first through a single full-adder cell and a carry flop, then pulses done.
//   clk, rst        : clock and synchronous active-high reset
//   start, sub      : request and mode (0 = a+b, 1 = a-b), sampled in idle only
//   a, b            : operands, sampled with start
//   busy            : high while bits are being processed
//   done            : one-cycle pulse when the result becomes valid
//   sum, cout, ovf  : result, final carry (sub: 1 = no borrow), two's-complement overflow
module serial_adder_n
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // One extra bit so WIDTH=1 still gets a non-zero-width counter.
  localparam int unsigned       CntW    = clog2(WIDTH + 1);
  localparam logic [CntW-1:0]   LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             fa_s, fa_c;

  fa_bit u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = done_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
          a_d     = a;
          b_d     = (sub == ModeSub) ? ~b : b;
          carry_d = (sub == ModeSub);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        // Result bits enter at the MSB; after WIDTH shifts bit 0 sits at position 0.
        sum_d   = (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_c;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          cout_d  = fa_c;
          // carry_q here is the carry into the MSB.
          ovf_d   = carry_q ^ fa_c;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        done_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed and randomised checks of serial_adder_n at WIDTH=8, 1 and 32.
module tb_serial_adder_n;
  import serial_add_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // WIDTH=8 instance
  logic       start8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;

  serial_adder_n #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .sub   (sub8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8),
    .ovf   (ovf8)
  );

  // WIDTH=1 and WIDTH=32 instances share operand drivers, separate start lines
  logic [31:0] rx_a, rx_b;
  logic        rx_sub, start1, start32;
  logic        busy1, done1, cout1, ovf1;
  logic [0:0]  sum1;
  logic        busy32, done32, cout32, ovf32;
  logic [31:0] sum32;

  serial_adder_n #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .sub   (rx_sub),
    .a     (rx_a[0:0]),
    .b     (rx_b[0:0]),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1),
    .ovf   (ovf1)
  );

  serial_adder_n #(.WIDTH(32)) u_dut32 (
    .clk   (clk),
    .rst   (rst),
    .start (start32),
    .sub   (rx_sub),
    .a     (rx_a),
    .b     (rx_b),
    .busy  (busy32),
    .done  (done32),
    .sum   (sum32),
    .cout  (cout32),
    .ovf   (ovf32)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: returns {ovf, cout, sum} for a w-bit operation.
  function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                        input logic s);
    logic [32:0] mask, full;
    logic [31:0] xx, yy, r;
    logic        c, v;
    mask = (33'd1 << w) - 33'd1;
    xx   = x & mask[31:0];
    yy   = (s ? ~y : y) & mask[31:0];
    full = {1'b0, xx} + {1'b0, yy} + 33'(s);
    r    = full[31:0] & mask[31:0];
    c    = full[w];
    v    = (xx[w-1] == yy[w-1]) && (r[w-1] != xx[w-1]);
    return {v, c, r};
  endfunction

  // One WIDTH=8 operation observed over a fixed window. inj_at injects an extra start in that
  // busy cycle, rst_at pulses reset in that busy cycle (-1 disables either).
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tsub,
                      input int inj_at, input int rst_at,
                      output int n_done, output int first_done, output int n_busy);
    n_done = 0;
    first_done = -1;
    n_busy = 0;
    @(negedge clk);
    a8 = ta; b8 = tb; sub8 = tsub; start8 = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      if (busy8) n_busy++;
      if (done8) begin
        n_done++;
        if (first_done < 0) first_done = j;
      end
      if (j == 1) begin
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
      end
      if (rst_at > 0 && j == rst_at + 1) begin
        check_eq("rst_mid_busy", 64'(busy8), 64'd0);
        check_eq("rst_mid_sum", 64'(sum8), 64'd0);
        check_eq("rst_mid_cout", 64'(cout8), 64'd0);
        check_eq("rst_mid_ovf", 64'(ovf8), 64'd0);
        rst = 1'b0;
      end
      if (j == rst_at) rst = 1'b1;
      if (j == inj_at) begin
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; sub8 = ModeAdd;
      end
      if (inj_at > 0 && j == inj_at + 1) start8 = 1'b0;
    end
  endtask

  // Back-to-back random ops with start held high on the WIDTH=1 or WIDTH=32 instance.
  task automatic rand_run(input int w, input int nops);
    logic [33:0] exp;
    logic [31:0] s_obs;
    logic        d_obs, c_obs, v_obs, hold_pending;
    int          t, ops, prev_done, bound;
    t = 0; ops = 0; prev_done = -1; hold_pending = 1'b0;
    bound = nops * (w + 2) + 20;
    @(negedge clk);
    rx_a = $urandom; rx_b = $urandom; rx_sub = 1'($urandom);
    exp = model(w, rx_a, rx_b, rx_sub);
    if (w == 1) start1 = 1'b1; else start32 = 1'b1;
    while (ops < nops && t < bound) begin
      @(negedge clk);
      t++;
      d_obs = (w == 1) ? done1 : done32;
      s_obs = (w == 1) ? {31'd0, sum1} : sum32;
      c_obs = (w == 1) ? cout1 : cout32;
      v_obs = (w == 1) ? ovf1 : ovf32;
      if (hold_pending) begin
        check_eq("hold_sum", 64'(s_obs), 64'(exp[31:0]));
        check_eq("hold_cout_ovf", 64'({v_obs, c_obs}), 64'(exp[33:32]));
        hold_pending = 1'b0;
        exp = model(w, rx_a, rx_b, rx_sub);
      end
      if (d_obs) begin
        check_eq((w == 1) ? "w1_sum" : "w32_sum", 64'(s_obs), 64'(exp[31:0]));
        check_eq((w == 1) ? "w1_cout" : "w32_cout", 64'(c_obs), 64'(exp[32]));
        check_eq((w == 1) ? "w1_ovf" : "w32_ovf", 64'(v_obs), 64'(exp[33]));
        if (prev_done >= 0) check_eq("done_spacing", 64'(t - prev_done), 64'(w + 2));
        prev_done = t;
        ops++;
        rx_a = $urandom; rx_b = $urandom; rx_sub = 1'($urandom);
        hold_pending = 1'b1;
      end
    end
    start1 = 1'b0; start32 = 1'b0;
    check_eq("rand_ops_completed", 64'(ops), 64'(nops));
  endtask

  initial begin
    int nd, fd, nb;
    rst = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start1 = 1'b0; start32 = 1'b0; rx_sub = 1'b0; rx_a = '0; rx_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("reset_busy", 64'(busy8), 64'd0);
    check_eq("reset_done", 64'(done8), 64'd0);
    check_eq("reset_sum", 64'(sum8), 64'd0);
    check_eq("reset_cout_ovf", 64'({ovf8, cout8}), 64'd0);

    // 1: 3C + 05
    run8(8'h3C, 8'h05, ModeAdd, -1, -1, nd, fd, nb);
    check_eq("add1_sum", 64'(sum8), 64'h41);
    check_eq("add1_cout_ovf", 64'({ovf8, cout8}), 64'b00);
    check_eq("add1_latency", 64'(fd), 64'd9);
    check_eq("add1_busy_cycles", 64'(nb), 64'd8);
    check_eq("add1_done_pulses", 64'(nd), 64'd1);
    // Result holds while idle regardless of a/b/sub activity.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
    end
    check_eq("idle_hold_sum", 64'(sum8), 64'h41);

    // 2: carry out and signed overflow on add
    run8(8'hFF, 8'h01, ModeAdd, -1, -1, nd, fd, nb);
    check_eq("add2_sum", 64'(sum8), 64'h00);
    check_eq("add2_cout_ovf", 64'({ovf8, cout8}), 64'b01);
    run8(8'h7F, 8'h01, ModeAdd, -1, -1, nd, fd, nb);
    check_eq("add3_sum", 64'(sum8), 64'h80);
    check_eq("add3_cout_ovf", 64'({ovf8, cout8}), 64'b10);

    // 3: subtraction with borrow, and with signed overflow
    run8(8'h05, 8'h07, ModeSub, -1, -1, nd, fd, nb);
    check_eq("sub1_sum", 64'(sum8), 64'hFE);
    check_eq("sub1_cout_ovf", 64'({ovf8, cout8}), 64'b00);
    run8(8'h80, 8'h01, ModeSub, -1, -1, nd, fd, nb);
    check_eq("sub2_sum", 64'(sum8), 64'h7F);
    check_eq("sub2_cout_ovf", 64'({ovf8, cout8}), 64'b11);

    // 4: start during busy is ignored
    run8(8'h10, 8'h20, ModeAdd, 3, -1, nd, fd, nb);
    check_eq("busy_start_sum", 64'(sum8), 64'h30);
    check_eq("busy_start_done_pulses", 64'(nd), 64'd1);
    check_eq("busy_start_latency", 64'(fd), 64'd9);

    // 5: reset in the 4th busy cycle aborts, then a fresh op works
    run8(8'h12, 8'h34, ModeAdd, -1, 4, nd, fd, nb);
    check_eq("abort_done_pulses", 64'(nd), 64'd0);
    check_eq("abort_busy_cycles", 64'(nb), 64'd4);
    run8(8'h12, 8'h34, ModeAdd, -1, -1, nd, fd, nb);
    check_eq("after_abort_sum", 64'(sum8), 64'h46);
    check_eq("after_abort_done_pulses", 64'(nd), 64'd1);

    // 6: randomised back-to-back on the narrow and wide builds
    rand_run(1, 1000);
    rand_run(32, 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
